// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the RAM word address and hands
// captured instructions to decode over a valid/ready handshake.
module instruction_fetch #(
  parameter int                      DATA_SIZE    = 32,
  parameter int                      ADDRESS_SIZE = 16,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0,
  parameter logic [DATA_SIZE-1:0]    HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_SIZE-1:0]    fetch_in,
  output logic [ADDRESS_SIZE-1:0] address_out,
  output logic                    fetch_req,
  input  logic                    mem_busy,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_SIZE-1:0] redirect_target,
  output logic [DATA_SIZE-1:0]    instr_out,
  output logic [ADDRESS_SIZE-1:0] pc_out,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic                    halted,
  output logic [31:0]             fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_FULL   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDRESS_SIZE-1:0] pc_reg, pc_next;
  logic [ADDRESS_SIZE-1:0] pc_out_reg, pc_out_next;
  logic [DATA_SIZE-1:0]    instr_reg, instr_next;
  logic [31:0]             count_reg, count_next;

  logic held_halt;
  logic accept;
  logic capture;

  assign held_halt = (instr_reg == HALT_WORD);
  assign accept    = (state_reg == S_FULL) && instr_ready;

  // In FULL a new word may only be captured on the same edge the held one leaves.
  assign capture = fetch_req && !mem_busy && !redirect_valid &&
                   ((state_reg == S_FETCH) || accept);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC;
      pc_out_reg <= '0;
      instr_reg  <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      pc_out_reg <= pc_out_next;
      instr_reg  <= instr_next;
      count_reg  <= count_next;
    end
  end

  // Next-state logic; redirect overrides every other transition
  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (capture) state_next = S_FULL;
        end
        S_FULL: begin
          if (accept) begin
            if (held_halt)    state_next = S_HALTED;
            else if (capture) state_next = S_FULL;
            else              state_next = S_FETCH;
          end
        end
        S_HALTED: state_next = S_HALTED;
        default:  state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_next     = pc_reg;
    pc_out_next = pc_out_reg;
    instr_next  = instr_reg;
    count_next  = count_reg + {31'd0, accept};
    if (redirect_valid) begin
      pc_next = redirect_target;
    end else if (capture) begin
      instr_next  = fetch_in;
      pc_out_next = pc_reg;
      pc_next     = pc_reg + 1'b1;
    end
  end

  // Output logic
  always_comb begin
    fetch_req   = !reset && ((state_reg == S_FETCH) ||
                             ((state_reg == S_FULL) && !held_halt));
    instr_valid = (state_reg == S_FULL);
    halted      = (state_reg == S_HALTED);
    address_out = pc_reg;
    pc_out      = pc_out_reg;
    instr_out   = instr_reg;
    fetch_count = count_reg;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the fetch rules.
module tb_instruction_fetch;

  localparam int          DW   = 32;
  localparam int          AW   = 16;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] fetch_in;
  logic [AW-1:0] address_out;
  logic          fetch_req;
  logic          mem_busy = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          halted;
  logic [31:0]   fetch_count;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  // Model of architectural behaviour: what decode should currently see.
  logic [AW-1:0] m_pc;
  logic          m_valid, m_halted;
  logic [DW-1:0] m_instr;
  logic [AW-1:0] m_ipc;
  logic [31:0]   m_count;

  always #5 clk = ~clk;

  assign fetch_in = mem[address_out];

  instruction_fetch #(
    .DATA_SIZE(DW), .ADDRESS_SIZE(AW), .RESET_PC(16'h0000), .HALT_WORD(HALT)
  ) dut (
    .clk(clk), .reset(reset), .fetch_in(fetch_in), .address_out(address_out),
    .fetch_req(fetch_req), .mem_busy(mem_busy), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted),
    .fetch_count(fetch_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply a rule-level model of one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic fetching;
    if (reset) begin
      m_pc = 16'h0000; m_valid = 0; m_halted = 0; m_instr = '0; m_ipc = '0; m_count = '0;
      return;
    end
    if (m_valid && instr_ready) m_count = m_count + 1;
    fetching = 0;
    if (redirect_valid) begin
      m_pc = redirect_target; m_valid = 0; m_halted = 0;
    end else if (!m_valid && !m_halted) begin
      fetching = !mem_busy;
    end else if (m_valid && instr_ready) begin
      if (m_instr == HALT) begin
        m_valid = 0; m_halted = 1;
      end else if (!mem_busy) begin
        fetching = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (fetching) begin
      m_instr = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 1'b1; m_valid = 1;
    end
  endtask

  task automatic step(input logic r, input logic b, input logic rv,
                      input logic [AW-1:0] t, input logic rd);
    logic exp_req;
    @(negedge clk);
    reset = r; mem_busy = b; redirect_valid = rv; redirect_target = t; instr_ready = rd;
    #1;
    exp_req = !reset && ((!m_valid && !m_halted) || (m_valid && m_instr != HALT));
    check_val("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check_val("halted",      {31'd0, halted},      {31'd0, m_halted});
    check_val("fetch_req",   {31'd0, fetch_req},   {31'd0, exp_req});
    check_val("address_out", {16'd0, address_out}, {16'd0, m_pc});
    check_val("instr_out",   instr_out,            m_instr);
    check_val("pc_out",      {16'd0, pc_out},      {16'd0, m_ipc});
    check_val("fetch_count", fetch_count,          m_count);
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44; mem[4] = 32'h55;
    mem[16'h0100] = 32'hA0; mem[16'h0101] = 32'hA1; mem[16'h0102] = 32'hA2;
    mem[16'hFFFF] = 32'hF0;
    m_pc = 0; m_valid = 0; m_halted = 0; m_instr = 0; m_ipc = 0; m_count = 0;

    // Reset, then stream words 0..3 at one per cycle
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    #2 check_val("count_after_4", fetch_count, 32'd4);

    // Stream with backpressure while 0x22 is held
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);                 // capture 0x11
    step(0, 0, 0, 0, 1);                 // accept 0x11, capture 0x22
    repeat (3) step(0, 0, 0, 0, 0);      // 0x22 held, address stays 2
    repeat (2) step(0, 0, 0, 0, 1);

    // mem_busy mid-stream, then redirect while FULL
    repeat (2) step(0, 1, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0100, 0);
    repeat (3) step(0, 0, 0, 0, 1);

    // Halt word at 3, then redirect back to 0 with simultaneous accept
    mem[3] = HALT;
    step(0, 0, 1, 16'h0000, 1);
    repeat (8) step(0, 0, 0, 0, 1);
    #2 check_val("halted_set", {31'd0, halted}, 32'd1);
    step(0, 0, 1, 16'h0000, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    // PC wrap from FFFF to 0000, then reset while FULL
    step(0, 0, 1, 16'hFFFF, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] tgt;
      tgt = $urandom_range(0, 1) ? AW'($urandom_range(0, 64)) : AW'(16'hFFF0 + $urandom_range(0, 15));
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           tgt,
           $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Instruction fetch stage directly upstream of the unified RAM block and directly feeding decode. It owns the program counter and drives the RAM word address. It captures the RAM instruction word (fetch_out) into an instruction register and hands it to decode over a valid/ready handshake. It supports branch redirect, yields the memory port to load/store when requested, and stops on a halt word.

Parameters:
DATA_SIZE, 32, instruction/data word width
ADDRESS_SIZE, 16, RAM word-address width; PC is word-addressed
RESET_PC, 0, PC value after reset
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
fetch_in  input  DATA_SIZE  instruction word from RAM fetch_out; combinational from address_out
address_out  output  ADDRESS_SIZE  word address to RAM when fetch owns the port
fetch_req  output  1  fetch wants the RAM port this cycle
mem_busy  input  1  load/store owns the RAM port; fetch must not capture
redirect_valid  input  1  taken branch/jump from execute
redirect_target  input  ADDRESS_SIZE  new PC on redirect
instr_out  output  DATA_SIZE  instruction to decode
pc_out  output  ADDRESS_SIZE  address instr_out was fetched from
instr_valid  output  1  instr_out/pc_out valid
instr_ready  input  1  decode accepts this cycle
halted  output  1  halt word accepted; fetch stopped
fetch_count  output  32  count of instructions accepted by decode

Behaviour:
- Reset is synchronous and active-high. It applies on the clk edge while reset=1 and overrides all other inputs:
  - pc=RESET_PC, address_out=RESET_PC, state=FETCH.
  - instr_out=0, pc_out=0, instr_valid=0, halted=0, fetch_count=0, fetch_req=0 during reset.
  - Reset mid-operation discards any held instruction.
- address_out always equals the internal pc. fetch_req=1 in FETCH, and in FULL when the held instruction is not HALT_WORD; otherwise 0.
- "capture" = fetch_req & ~mem_busy & ~redirect_valid at the edge.
- Capture loads instr_out<=fetch_in, pc_out<=pc, pc<=pc+1 (modulo 2^ADDRESS_SIZE: 16'hFFFF wraps to 0), instr_valid<=1.
- "accept" = instr_valid & instr_ready. fetch_count increments by 1 per accept and wraps at 2^32.
- States and transitions:
  - FETCH: instr_valid=0. Capture -> FULL. No capture -> stay in FETCH with pc unchanged.
  - FULL: instr_valid=1.
    - Accept with held word != HALT_WORD: capture the next word in the same edge if allowed (back-to-back, 1 instr/cycle), stay FULL. If capture is blocked by mem_busy -> FETCH.
    - Accept with held word == HALT_WORD -> HALTED, instr_valid<=0. The halt word itself is delivered to decode.
    - No accept: hold instr_out/pc_out stable, no capture, pc unchanged.
  - HALTED: halted=1, instr_valid=0, fetch_req=0. Leaves only on redirect or reset.
- Redirect has priority over capture, accept-advance and halt, in any state:
  - pc<=redirect_target, instr_valid<=0, halted<=0, state<=FETCH. The held instruction is discarded.
  - If decode accepts in the same cycle, that accept still counts in fetch_count.
  - The first fetch from the target occurs on the following edge.
- Latency: the first valid instruction appears 1 edge after reset deasserts, and 1 edge after the cycle following a redirect.
- mem_busy=1 only blocks capture. The held instruction may still be accepted.
- Simultaneous accept and redirect: accept counted, redirect wins the state.

Test Plan:
- Reset, RAM words 0..3 = 32'h11,22,33,44, instr_ready=1 -> instr_out 11,22,33,44 on consecutive cycles, pc_out 0,1,2,3, fetch_count=4.
- instr_ready=0 for 3 cycles with instr 32'h22 held -> instr_out/pc_out stable, address_out stays 2. Then ready=1 -> 32'h33 the next cycle.
- mem_busy=1 for 2 cycles mid-stream -> no capture, instr_valid drops after the held word is accepted. Resumes at the correct pc with no skipped or duplicated word.
- redirect_valid=1, target=16'h0100, while FULL -> held word dropped, instr_valid=0 for one cycle, next pc_out=16'h0100.
- Word at 3 = HALT_WORD -> halt word delivered, then halted=1, fetch_req=0, fetch_count frozen. Redirect to 0 clears halted and refetches from 0.
- RESET_PC=16'hFFFF -> pc_out sequence FFFF, 0000. Reset asserted while FULL -> all outputs at reset values next edge.
